ray_column_writer: RTL and testbench

// - Consumes per-ray DDA results from the dda_fifo_out FIFO (AXI-Stream, 39-bit) and expands each ray into a full

---
 rtl/ray_column_writer.sv | 179 +++++++++++++++++
 tb/tb_ray_column_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ray_column_writer.sv
// ray_column_writer
// Expands each per-ray DDA result into a full screen column of frame-buffer
// writes (ceiling, wall slice, floor), one pixel per clock, in y order.
//
// Ports:
//   pixel_clk_in            pixel clock, rising edge
//   rst_in                  asynchronous reset, active-low
//   dda_fifo_tvalid_in      FIFO holds a ray
//   dda_fifo_tdata_in       [38:30] column x, [29:22] line height h,
//                           [21:20] wall type, [19] side, [18:0] unused
//   dda_fifo_tlast_in       ray is the last of the frame
//   transformer_tready_out  ready to accept a ray
//   ray_valid_out           address/pixel valid this cycle
//   ray_address_out         y*SCREEN_W + x
//   ray_pixel_out           RGB565 pixel
//   ray_last_pixel_out      final pixel of the final ray of a frame
//   ray_err_out             sticky: a ray with x >= SCREEN_W was dropped
module ray_column_writer #(
    parameter int          SCREEN_W    = 320,
    parameter int          SCREEN_H    = 180,
    parameter logic [15:0] CEIL_COLOR  = 16'h18E3,
    parameter logic [15:0] FLOOR_COLOR = 16'h4208
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        dda_fifo_tvalid_in,
    input  logic [38:0] dda_fifo_tdata_in,
    input  logic        dda_fifo_tlast_in,
    output logic        transformer_tready_out,
    output logic        ray_valid_out,
    output logic [15:0] ray_address_out,
    output logic [15:0] ray_pixel_out,
    output logic        ray_last_pixel_out,
    output logic        ray_err_out
);

    localparam logic [15:0] W16      = 16'(SCREEN_W);
    localparam logic [15:0] H16      = 16'(SCREEN_H);
    localparam logic [15:0] LAST_ROW = 16'(SCREEN_H - 1);

    typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

    function automatic logic [15:0] wall_color(input logic [1:0] kind, input logic side);
        logic [15:0] c;
        case (kind)
            2'd0:    c = 16'hF800;
            2'd1:    c = 16'h07E0;
            2'd2:    c = 16'h001F;
            default: c = 16'hFFFF;
        endcase
        // Halving each RGB565 channel: the mask clears bits shifted across channel borders.
        if (side) c = (c >> 1) & 16'h7BEF;
        return c;
    endfunction

    function automatic logic [15:0] row_pixel(input logic [15:0] row, input logic [15:0] first,
                                              input logic [15:0] stop, input logic [15:0] wall);
        if (row < first)     return CEIL_COLOR;
        else if (row < stop) return wall;
        else                 return FLOOR_COLOR;
    endfunction

    state_t      state, state_next;
    logic        armed;
    logic [15:0] y, row_base;
    logic [8:0]  col_x;
    logic [15:0] row_start, row_end, col_wall;
    logic        col_last;

    logic [8:0]  in_x;
    logic [7:0]  in_h;
    logic [15:0] in_hc, in_start, in_end, in_wall;
    logic        at_last_row, accept, x_ok;
    logic        load, step, drop, emit;
    logic [15:0] sel_y, sel_base, sel_start, sel_end, sel_wall;
    logic [8:0]  sel_x;
    logic        sel_last;
    logic        unused_bits;

    assign unused_bits = ^dda_fifo_tdata_in[18:0];

    // Decode of the ray presented by the FIFO: wall span is centred vertically.
    assign in_x     = dda_fifo_tdata_in[38:30];
    assign in_h     = dda_fifo_tdata_in[29:22];
    assign in_hc    = ({8'd0, in_h} >= H16) ? H16 : {8'd0, in_h};
    assign in_start = (H16 - in_hc) >> 1;
    assign in_end   = in_start + in_hc;
    assign in_wall  = wall_color(dda_fifo_tdata_in[21:20], dda_fifo_tdata_in[19]);
    assign x_ok     = {7'd0, in_x} < W16;

    // armed keeps tready low until the first clock after reset release.
    assign at_last_row            = (y == LAST_ROW);
    assign transformer_tready_out = armed & ((state == IDLE) | at_last_row);
    assign accept                 = dda_fifo_tvalid_in & transformer_tready_out;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (x_ok) begin
                        load       = 1'b1;
                        state_next = DRAW;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (!at_last_row) begin
                    step = 1'b1;
                end else if (accept && x_ok) begin
                    load = 1'b1;
                end else begin
                    drop       = accept;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Row about to be emitted: row 0 of a new ray, or the next row of the current one.
    always_comb begin
        emit      = load | step;
        sel_y     = load ? 16'd0 : y + 16'd1;
        sel_base  = load ? 16'd0 : row_base + W16;
        sel_x     = load ? in_x : col_x;
        sel_start = load ? in_start : row_start;
        sel_end   = load ? in_end : row_end;
        sel_wall  = load ? in_wall : col_wall;
        sel_last  = load ? dda_fifo_tlast_in : col_last;
    end

    // Stage: registered pixel output
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            armed              <= 1'b0;
            y                  <= 16'd0;
            row_base           <= 16'd0;
            ray_valid_out      <= 1'b0;
            ray_address_out    <= 16'd0;
            ray_pixel_out      <= 16'd0;
            ray_last_pixel_out <= 1'b0;
            ray_err_out        <= 1'b0;
        end else begin
            armed              <= 1'b1;
            ray_valid_out      <= emit;
            ray_last_pixel_out <= emit & sel_last & (sel_y == LAST_ROW);
            ray_err_out        <= ray_err_out | drop;
            if (emit) begin
                y               <= sel_y;
                row_base        <= sel_base;
                ray_address_out <= sel_base + {7'd0, sel_x};
                ray_pixel_out   <= row_pixel(sel_y, sel_start, sel_end, sel_wall);
            end
        end
    end

    // Per-ray parameters, captured on accept
    always_ff @(posedge pixel_clk_in) begin
        if (load) begin
            col_x     <= in_x;
            row_start <= in_start;
            row_end   <= in_end;
            col_wall  <= in_wall;
            col_last  <= dda_fifo_tlast_in;
        end
    end

endmodule

// File: tb/tb_ray_column_writer.sv
// tb_ray_column_writer
// Directed and randomized rays driven into ray_column_writer; every write is
// compared with a queue of expected writes built from the column rules.
module tb_ray_column_writer;

    localparam int W = 320;
    localparam int H = 180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tvalid = 1'b0;
    logic [38:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tready, valid, last, err;
    logic [15:0] addr, pix;

    ray_column_writer dut (
        .pixel_clk_in          (clk),
        .rst_in                (rst_n),
        .dda_fifo_tvalid_in    (tvalid),
        .dda_fifo_tdata_in     (tdata),
        .dda_fifo_tlast_in     (tlast),
        .transformer_tready_out(tready),
        .ray_valid_out         (valid),
        .ray_address_out       (addr),
        .ray_pixel_out         (pix),
        .ray_last_pixel_out    (last),
        .ray_err_out           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] p;
        logic        l;
    } wr_t;

    wr_t  q[$];
    int   total = 0;
    int   passed = 0;
    logic exp_err = 1'b0;
    logic armed_m;
    bit   mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model_pix(input int y, input int h, input int t, input int s);
        int hc, st, en;
        logic [15:0] c;
        hc = (h > H) ? H : h;
        st = (H - hc) / 2;
        en = st + hc;
        if (y < st) return 16'h18E3;
        if (y >= en) return 16'h4208;
        case (t)
            0:       c = 16'hF800;
            1:       c = 16'h07E0;
            2:       c = 16'h001F;
            default: c = 16'hFFFF;
        endcase
        if (s != 0) c = (c >> 1) & 16'h7BEF;
        return c;
    endfunction

    task automatic push_ray(input int x, input int h, input int t, input int s, input int l);
        wr_t e;
        if (x >= W) begin
            exp_err = 1'b1;
        end else begin
            for (int y = 0; y < H; y++) begin
                e.a = 16'(y * W + x);
                e.p = model_pix(y, h, t, s);
                e.l = (l != 0) && (y == H - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic send_ray(input int x, input int h, input int t, input int s, input int l);
        int n;
        n = 0;
        tdata  = {9'(x), 8'(h), 2'(t), 1'(s), 19'($urandom)};
        tlast  = (l != 0);
        tvalid = 1'b1;
        while (tready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("handshake_timeout", {31'd0, tready}, 32'd1);
            tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        push_ray(x, h, t, s, l);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_m <= 1'b0;
        else        armed_m <= 1'b1;
    end

    always @(negedge clk) begin
        wr_t e;
        if (mon_on) begin
            if (!rst_n) begin
                chk("rst_valid", {31'd0, valid}, 32'd0);
                chk("rst_ready", {31'd0, tready}, 32'd0);
                chk("rst_addr", {16'd0, addr}, 32'd0);
                chk("rst_pix", {16'd0, pix}, 32'd0);
                chk("rst_last", {31'd0, last}, 32'd0);
                chk("rst_err", {31'd0, err}, 32'd0);
            end else begin
                chk("tready", {31'd0, tready}, {31'd0, (armed_m === 1'b1) && (q.size() <= 1)});
                chk("valid", {31'd0, valid}, {31'd0, q.size() > 0});
                chk("err", {31'd0, err}, {31'd0, exp_err});
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("addr", {16'd0, addr}, {16'd0, e.a});
                    chk("pixel", {16'd0, pix}, {16'd0, e.p});
                    chk("last", {31'd0, last}, {31'd0, e.l});
                end else begin
                    chk("last_idle", {31'd0, last}, 32'd0);
                end
            end
        end
    end

    initial begin
        int gap;
        #2 rst_n = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);

        // Reset release: tready rises one cycle later.
        rst_n = 1'b1;
        #1;
        chk("t1_ready_at_release", {31'd0, tready}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_ready_after", {31'd0, tready}, 32'd1);
        chk("t1_valid", {31'd0, valid}, 32'd0);
        chk("t1_addr", {16'd0, addr}, 32'd0);
        chk("t1_pix", {16'd0, pix}, 32'd0);
        repeat (2) @(negedge clk);

        // Plain column, then a full-height shaded final ray.
        send_ray(5, 100, 0, 0, 0);
        drain();
        send_ray(319, 255, 2, 1, 1);
        drain();

        // Zero-height and one-pixel walls.
        send_ray(0, 0, 0, 0, 0);
        send_ray(0, 1, 1, 0, 0);
        drain();

        // Back-to-back rays, reset at y=50 of the second.
        send_ray(10, 50, 1, 1, 0);
        send_ray(20, 200, 3, 0, 1);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #1;
        q.delete();
        exp_err = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_valid_reset", {31'd0, valid}, 32'd0);
        chk("t5_last_reset", {31'd0, last}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Out-of-range column is dropped; error is sticky.
        send_ray(320, 80, 0, 0, 1);
        @(negedge clk);
        chk("t6_err_set", {31'd0, err}, 32'd1);
        repeat (5) @(negedge clk);
        chk("t6_err_sticky", {31'd0, err}, 32'd1);
        send_ray(100, 80, 3, 1, 0);
        drain();

        // Randomized rays with random gaps, including out-of-range columns.
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            send_ray($urandom_range(0, 335), $urandom_range(0, 255), $urandom_range(0, 3),
                     $urandom_range(0, 1), $urandom_range(0, 1));
        end
        drain();
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
